alu_sequencer: RTL and testbench
================================

# alu_sequencer

Initiator-side controller for the 32-bit gate-level ALU. Accepts operation requests over a valid/ready handshake and drives the ALU's command and operand inputs from registers. Waits a fixed number of settle cycles so the ripple-delay ALU can resolve, then captures result, carry-out, overflow and zero. Returns them over a valid/ready response channel. It is the only block that talks to the ALU, so the rest of the datapath sees a clean, synchronous, multi-cycle execute unit.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles the ALU inputs are held stable before capture. Must be ≥ 1; a value of 0 is an elaboration error.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `req_valid` input, 1: a request is present.
- `req_ready` output, 1: the sequencer can accept a request.
- `req_cmd` input, 3: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 OR, 7 NOR.
- `req_a`, `req_b` input, 32: operands.
- `alu_command` output, 3: drives the ALU command input.
- `alu_a`, `alu_b` output, 32: drive the ALU operand inputs.
- `alu_out` input, 32: ALU result.
- `alu_carryout`, `alu_overflow`, `alu_zero` input, 1 each: ALU flags.
- `rsp_valid` output, 1: a response is held.
- `rsp_ready` input, 1: the consumer takes the response.
- `rsp_result` output, 32: captured ALU result.
- `rsp_carryout`, `rsp_overflow`, `rsp_zero` output, 1 each: captured ALU flags.
- `rsp_error` output, 1: golden-model mismatch (see Configuration).

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid & req_ready`: register `req_cmd`, `req_a` and `req_b` into `alu_command`, `alu_a` and `alu_b`.
  - Load the settle counter with `SETTLE_CYCLES-1`, then go to DRIVE.
- DRIVE
  - `req_ready`=0.
  - `alu_*` are held constant.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture `alu_out` and the three flags into the `rsp_*` registers, then go to RESP.
- RESP
  - `rsp_valid`=1.
  - All `rsp_*` signals are stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: go to IDLE. `rsp_*` data keeps its last value; only `rsp_valid` drops.
- `alu_*` keep their last values outside DRIVE; they are reloaded only on acceptance.
- Flags pass through unmodified. The ALU already gates carry and overflow to 0 for non-ADD/SUB commands.
- Settle counter width is `$clog2(SETTLE_CYCLES+1)`.
- Requests presented while `req_ready`=0 are ignored and not queued. The requester must hold `req_valid` and its data until accepted.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1, `rsp_valid`=0.
  - `alu_command`=0, `alu_a`=0, `alu_b`=0.
  - `rsp_result`=0, `rsp_carryout`=0, `rsp_overflow`=0, `rsp_zero`=0, `rsp_error`=0.
- Acceptance on edge E makes `alu_*` valid immediately after E.
- Capture happens on edge E+`SETTLE_CYCLES`.
- `rsp_valid` is high from edge E+`SETTLE_CYCLES` until the edge where `rsp_ready` is sampled high.
- `SETTLE_CYCLES`=1 is legal: the ALU inputs are stable for exactly one cycle.
- Throughput: at most one operation per `SETTLE_CYCLES`+2 cycles. The path is RESP→IDLE→accept; there is no RESP-to-DRIVE bypass.
- `rsp_ready` held high continuously: RESP lasts exactly one cycle.
- Reset mid-operation, in DRIVE or RESP: return to IDLE with all reset values on the next edge. The in-flight response is discarded.
- Reset and `req_valid` in the same cycle: reset wins and the request is not accepted.

## Configuration
- Macro `ALU_SEQUENCER_CHECK_EN`.
- Defined: instantiate the golden model `alu_seq_ref`.
  - The model computes the expected result from the registered command and operands.
  - SLT is signed and yields 32'd1 or 32'd0. NAND and NOR are bitwise inversions.
  - Zero is always compared. Carry-out and overflow are compared for ADD/SUB only.
  - `rsp_error` is registered at capture alongside `rsp_result` and is 1 on any mismatch.
- Not defined: no model is present and `rsp_error` is tied to 0.

## Structure
- Package `alu_seq_pkg` holds:
  - the command localparams `CMD_ADD`..`CMD_NOR` (0..7), matching the ALU's encoding;
  - the state encoding IDLE=0, DRIVE=1, RESP=2.
- Sub-module `alu_seq_ref` is purely combinational and instantiated only under `ALU_SEQUENCER_CHECK_EN`.
- The top level contains only the FSM, counter and registers.

## Test plan
- The bench connects the real ALU.
- The clock period times `SETTLE_CYCLES` must exceed the ALU's worst-case gate delay.

Scenarios:
- Reset, then ADD a=0xFFFFFFFF, b=1 → `rsp_result`=0, carry=1, overflow=0, zero=1, `rsp_valid` exactly `SETTLE_CYCLES` edges after acceptance.
- SUB a=5, b=7 → result 0xFFFFFFFE, carry=0, zero=0. ADD a=0x7FFFFFFF, b=1 → result 0x80000000, overflow=1.
- SLT a=0x7FFFFFFF, b=0x7FFFFFFE → 0. SLT a=0x80000000, b=1 → 1. NOR a=b=0 → 0xFFFFFFFF. NAND a=b=0xFFFFFFFF → 0, zero=1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles and change `req_*` meanwhile → `rsp_*` and `alu_*` stable, `req_ready`=0. Releasing `rsp_ready` gives IDLE on the next edge.
- Assert `reset` during DRIVE → next cycle `req_ready`=1, `rsp_valid`=0, `alu_*`=0, and no response ever appears for that request.
- Checker build: force `alu_out`=0x1 on an XOR a=b=0x5 → `rsp_error`=1. Without the macro, `rsp_error` stays 0 for all of the scenarios above.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared command encoding and FSM state type for the ALU sequencer.
package alu_seq_pkg;

    // ALU command encoding, identical to the gate-level ALU's command input
    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_OR   = 3'd6;
    localparam logic [2:0] CMD_NOR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request channel, ALU drive/return wires and response channel
// of the ALU sequencer. The slave modport is the sequencer itself; the master
// modport is its environment (requester, consumer and the ALU).
interface alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [2:0]  alu_command;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_carryout;
    logic        alu_overflow;
    logic        alu_zero;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_error;

    modport slave (
        input  req_valid, req_cmd, req_a, req_b,
        input  alu_out, alu_carryout, alu_overflow, alu_zero,
        input  rsp_ready,
        output req_ready,
        output alu_command, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero, rsp_error
    );

    modport master (
        output req_valid, req_cmd, req_a, req_b,
        output alu_out, alu_carryout, alu_overflow, alu_zero,
        output rsp_ready,
        input  req_ready,
        input  alu_command, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero, rsp_error
    );

endinterface

// File: rtl/alu_seq_ref.sv
// alu_seq_ref: combinational golden model of the ALU. Flags a mismatch between
// what the ALU returned and what the registered command/operands should give.
module alu_seq_ref
    import alu_seq_pkg::*;
(
    input  logic [2:0]  cmd,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] alu_out,
    input  logic        alu_carryout,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        mismatch
);

    logic [31:0] exp_result;
    logic        exp_carry;
    logic        exp_overflow;
    logic        is_arith;
    logic [32:0] sum_ext;
    logic [32:0] diff_ext;

    // Expected result and flags; subtraction is a + ~b + 1 so carry means "no borrow"
    always_comb begin
        exp_result   = 32'd0;
        exp_carry    = 1'b0;
        exp_overflow = 1'b0;
        is_arith     = 1'b0;
        sum_ext      = {1'b0, a} + {1'b0, b};
        diff_ext     = {1'b0, a} + {1'b0, ~b} + 33'd1;
        case (cmd)
            CMD_ADD: begin
                is_arith     = 1'b1;
                exp_result   = sum_ext[31:0];
                exp_carry    = sum_ext[32];
                exp_overflow = (a[31] == b[31]) && (sum_ext[31] != a[31]);
            end
            CMD_SUB: begin
                is_arith     = 1'b1;
                exp_result   = diff_ext[31:0];
                exp_carry    = diff_ext[32];
                exp_overflow = (a[31] != b[31]) && (diff_ext[31] != a[31]);
            end
            CMD_XOR:  exp_result = a ^ b;
            CMD_SLT:  exp_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            CMD_AND:  exp_result = a & b;
            CMD_NAND: exp_result = ~(a & b);
            CMD_OR:   exp_result = a | b;
            default:  exp_result = ~(a | b);
        endcase
        mismatch = (alu_out != exp_result)
                 | (alu_zero != (exp_result == 32'd0))
                 | (is_arith & ((alu_carryout != exp_carry) | (alu_overflow != exp_overflow)));
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts an ALU request, holds the ALU inputs for SETTLE_CYCLES
// cycles so the ripple-delay ALU can resolve, then captures and returns its
// result and flags. Define ALU_SEQUENCER_CHECK_EN to build in the golden-model
// checker that drives rsp_error; otherwise rsp_error is always 0.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("alu_sequencer: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             error_q, error_d;
    logic             check_mismatch;

`ifdef ALU_SEQUENCER_CHECK_EN
    alu_seq_ref u_ref (
        .cmd          (cmd_q),
        .a            (a_q),
        .b            (b_q),
        .alu_out      (bus.alu_out),
        .alu_carryout (bus.alu_carryout),
        .alu_overflow (bus.alu_overflow),
        .alu_zero     (bus.alu_zero),
        .mismatch     (check_mismatch)
    );
`else
    assign check_mismatch = 1'b0;
`endif

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.alu_command  = cmd_q;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_carryout = carry_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_error    = error_q;

    // Next-state logic: load operands on acceptance, count down the settle window, capture, then wait for the consumer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cmd_d   = bus.req_cmd;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    cnt_d   = CNT_LOAD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    result_d = bus.alu_out;
                    carry_d  = bus.alu_carryout;
                    ovf_d    = bus.alu_overflow;
                    zero_d   = bus.alu_zero;
                    error_d  = check_mismatch;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and datapath registers; synchronous reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer with a behavioural
// stand-in for the ripple-delay ALU (slower than one clock, faster than the
// settle window). Honours ALU_SEQUENCER_CHECK_EN for the rsp_error expectation.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int SETTLE = 4;
    localparam int ALU_DELAY = 12;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        c;
        logic        v;
        logic        z;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic force_en = 1'b0;
    logic [31:0] force_val = 32'd0;

    logic [31:0] model_out;
    logic        model_c;
    logic        model_v;
    logic [32:0] model_ext;

    int passCount = 0;
    int checkCount = 0;
    vec_t expQ[$];
    vec_t vecs[10];

    alu_sequencer_if bus ();

    alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Behavioural ALU: carry/overflow gated to 0 outside ADD/SUB
    always_comb begin
        model_out = 32'd0;
        model_c   = 1'b0;
        model_v   = 1'b0;
        model_ext = 33'd0;
        case (bus.alu_command)
            CMD_ADD: begin
                model_ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                model_out = model_ext[31:0];
                model_c   = model_ext[32];
                model_v   = (bus.alu_a[31] == bus.alu_b[31]) && (model_out[31] != bus.alu_a[31]);
            end
            CMD_SUB: begin
                model_ext = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
                model_out = model_ext[31:0];
                model_c   = model_ext[32];
                model_v   = (bus.alu_a[31] != bus.alu_b[31]) && (model_out[31] != bus.alu_a[31]);
            end
            CMD_XOR:  model_out = bus.alu_a ^ bus.alu_b;
            CMD_SLT:  model_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            CMD_AND:  model_out = bus.alu_a & bus.alu_b;
            CMD_NAND: model_out = ~(bus.alu_a & bus.alu_b);
            CMD_OR:   model_out = bus.alu_a | bus.alu_b;
            default:  model_out = ~(bus.alu_a | bus.alu_b);
        endcase
    end

    assign #ALU_DELAY bus.alu_out      = force_en ? force_val : model_out;
    assign #ALU_DELAY bus.alu_carryout = force_en ? 1'b0 : model_c;
    assign #ALU_DELAY bus.alu_overflow = force_en ? 1'b0 : model_v;
    assign #ALU_DELAY bus.alu_zero     = force_en ? (force_val == 32'd0) : (model_out == 32'd0);

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checkEq("req_ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_cmd   = v.cmd;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkEq("alu_command", 32'(bus.alu_command), 32'(v.cmd));
        checkEq("alu_a", bus.alu_a, v.a);
        checkEq("alu_b", bus.alu_b, v.b);
        checkEq("req_ready_drive", 32'(bus.req_ready), 32'd0);
    endtask

    task automatic checkOutput();
        vec_t e;
        int lat = 0;
        for (int k = 1; k <= SETTLE + 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
        checkEq("rsp_latency", 32'(lat), 32'(SETTLE));
        if (lat == 0) begin
            void'(expQ.pop_front());
            return;
        end
        e = expQ.pop_front();
        checkEq("rsp_result", bus.rsp_result, e.result);
        checkEq("rsp_carryout", 32'(bus.rsp_carryout), 32'(e.c));
        checkEq("rsp_overflow", 32'(bus.rsp_overflow), 32'(e.v));
        checkEq("rsp_zero", 32'(bus.rsp_zero), 32'(e.z));
        checkEq("rsp_error", 32'(bus.rsp_error), 32'(e.err));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkEq("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        checkEq("req_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence
    initial begin
        vec_t bp;
        vec_t v;
        int accCycles[$];
        int rspCount;
        int seen;

        vecs[0] = '{CMD_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{CMD_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{CMD_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{CMD_SLT,  32'h7FFFFFFF, 32'h7FFFFFFE, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{CMD_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{CMD_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{CMD_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{CMD_XOR,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{CMD_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{CMD_OR,   32'h0F0F0000, 32'h00F0000F, 32'h0FFF000F, 1'b0, 1'b0, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkEq("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkEq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkEq("reset_alu_command", 32'(bus.alu_command), 32'd0);
        checkEq("reset_alu_a", bus.alu_a, 32'd0);
        checkEq("reset_alu_b", bus.alu_b, 32'd0);
        checkEq("reset_rsp_result", bus.rsp_result, 32'd0);
        checkEq("reset_rsp_flags", {28'd0, bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Backpressure: response and ALU inputs stay frozen while requests churn
        bp = '{CMD_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(bp);
        seen = 0;
        for (int k = 0; k < SETTLE + 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        checkEq("bp_rsp_appears", 32'(seen), 32'd1);
        v = expQ.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_cmd   = 3'($urandom_range(0, 7));
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            @(posedge clk);
            #1;
            checkEq("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkEq("bp_req_ready", 32'(bus.req_ready), 32'd0);
            checkEq("bp_rsp_result", bus.rsp_result, v.result);
            checkEq("bp_alu_a", bus.alu_a, v.a);
            checkEq("bp_alu_b", bus.alu_b, v.b);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkEq("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkEq("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
        checkEq("bp_release_result_kept", bus.rsp_result, v.result);

        // Reset and a request in the same cycle: reset wins
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_cmd   = CMD_XOR;
        bus.req_a     = 32'h0000AAAA;
        bus.req_b     = 32'h00005555;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        checkEq("rstreq_alu_a", bus.alu_a, 32'd0);
        checkEq("rstreq_alu_command", 32'(bus.alu_command), 32'd0);
        checkEq("rstreq_req_ready", 32'(bus.req_ready), 32'd1);
        checkEq("rstreq_rsp_result", bus.rsp_result, 32'd0);
        @(posedge clk);
        #1;
        checkEq("rstreq_not_accepted", 32'(bus.req_ready), 32'd1);

        // Reset during DRIVE discards the in-flight operation
        applyStimulus('{CMD_SUB, 32'd9, 32'd2, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        checkEq("rstdrv_req_ready", 32'(bus.req_ready), 32'd1);
        checkEq("rstdrv_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkEq("rstdrv_alu_a", bus.alu_a, 32'd0);
        checkEq("rstdrv_alu_b", bus.alu_b, 32'd0);
        checkEq("rstdrv_alu_command", 32'(bus.alu_command), 32'd0);
        seen = 0;
        repeat (SETTLE + 5) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen = 1;
        end
        checkEq("rstdrv_no_response", 32'(seen), 32'd0);

        // Back-to-back requests with rsp_ready held high: SETTLE+2 cycles apart, one-cycle RESP
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_cmd   = CMD_ADD;
        bus.req_a     = 32'd1;
        bus.req_b     = 32'd2;
        rspCount = 0;
        for (int cyc = 0; cyc < 40 && accCycles.size() < 2; cyc++) begin
            if (bus.req_ready && bus.req_valid) accCycles.push_back(cyc);
            if (bus.rsp_valid) rspCount++;
            if (accCycles.size() < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkEq("tput_two_accepts", 32'(accCycles.size()), 32'd2);
        if (accCycles.size() == 2)
            checkEq("tput_accept_spacing", 32'(accCycles[1] - accCycles[0]), 32'(SETTLE + 2));
        checkEq("tput_resp_one_cycle", 32'(rspCount), 32'd1);
        rspCount = 0;
        for (int k = 0; k < SETTLE + 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) rspCount++;
        end
        checkEq("tput_second_resp_one_cycle", 32'(rspCount), 32'd1);
        checkEq("tput_result", bus.rsp_result, 32'd3);
        bus.rsp_ready = 1'b0;

        // Corrupted ALU output on XOR 5^5: flagged only in the checker build
        force_en  = 1'b1;
        force_val = 32'h00000001;
`ifdef ALU_SEQUENCER_CHECK_EN
        applyStimulus('{CMD_XOR, 32'h5, 32'h5, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1});
`else
        applyStimulus('{CMD_XOR, 32'h5, 32'h5, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0});
`endif
        checkOutput();
        force_en = 1'b0;

        // A clean operation after the corrupted one clears rsp_error
        applyStimulus(vecs[8]);
        checkOutput();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
